// File: rtl/cordic_iter_ctrl.sv
// Iterative sequencer for a single circular-rotation CORDIC stage: loads one (x,y,z) operand,
// feeds the stage from local registers for p_ITER cycles and hands the result downstream.
module cordic_iter_ctrl #(
    parameter  int p_WIDTH      = 32,
    parameter  int p_ITER       = 16,
    localparam int p_LOG2_WIDTH = $clog2(p_WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    // operand handshake
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [p_WIDTH-1:0]      i_x,
    input  logic [p_WIDTH-1:0]      i_y,
    input  logic [p_WIDTH-1:0]      i_z,
    // to the iteration stage
    output logic [p_WIDTH-1:0]      o_xprev,
    output logic [p_WIDTH-1:0]      o_yprev,
    output logic [p_WIDTH-1:0]      o_zprev,
    output logic                    o_dprev,
    output logic                    o_mode,
    output logic [p_WIDTH-1:0]      o_lut,
    output logic [p_LOG2_WIDTH-1:0] o_shift_amnt,
    // from the iteration stage
    input  logic [p_WIDTH-1:0]      i_xnext,
    input  logic [p_WIDTH-1:0]      i_ynext,
    input  logic [p_WIDTH-1:0]      i_znext,
    // result handshake
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [p_WIDTH-1:0]      o_x,
    output logic [p_WIDTH-1:0]      o_y,
    output logic [p_WIDTH-1:0]      o_z,
    output logic                    o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [p_LOG2_WIDTH-1:0] LAST_CNT = p_LOG2_WIDTH'(p_ITER - 1);

    state_t                  state_q, state_d;
    logic [p_LOG2_WIDTH-1:0] cnt_q, cnt_d;
    logic [p_WIDTH-1:0]      x_q, y_q, z_q;
    logic [p_WIDTH-1:0]      x_d, y_d, z_d;
    logic                    accept;
    logic [31:0]             lut_q30;

    // floor(atan(2^-idx) * 2^30). From idx=10 on the cubic term is below one LSB,
    // so the entry is exactly 2^(30-idx)-1, reaching zero at idx=30.
    function automatic logic [31:0] atan_q30(input int idx);
        case (idx)
            0:       atan_q30 = 32'h3243_F6A8;
            1:       atan_q30 = 32'h1DAC_6705;
            2:       atan_q30 = 32'h0FAD_BAFC;
            3:       atan_q30 = 32'h07F5_6EA6;
            4:       atan_q30 = 32'h03FE_AB76;
            5:       atan_q30 = 32'h01FF_D55B;
            6:       atan_q30 = 32'h00FF_FAAA;
            7:       atan_q30 = 32'h007F_FF55;
            8:       atan_q30 = 32'h003F_FFEA;
            9:       atan_q30 = 32'h001F_FFFD;
            default: atan_q30 = (idx < 30) ? ((32'd1 << (30 - idx)) - 32'd1) : 32'd0;
        endcase
    endfunction

    assign o_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
    assign accept  = i_valid && o_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    x_d     = i_x;
                    y_d     = i_y;
                    z_d     = i_z;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                x_d = i_xnext;
                y_d = i_ynext;
                z_d = i_znext;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // Retiring and reloading share one edge so back-to-back operands lose no cycle.
                if (i_ready) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    x_d     = i_x;
                    y_d     = i_y;
                    z_d     = i_z;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        lut_q30 = atan_q30(int'(cnt_q));
    end

    // Narrower datapaths keep the top bits (a floor); wider ones are limited to 30 fraction bits.
    if (p_WIDTH <= 32) begin : g_lut_narrow
        assign o_lut = lut_q30[31 -: p_WIDTH];
    end else begin : g_lut_wide
        assign o_lut = {lut_q30, {(p_WIDTH - 32){1'b0}}};
    end

    assign o_xprev      = x_q;
    assign o_yprev      = y_q;
    assign o_zprev      = z_q;
    assign o_dprev      = ~z_q[p_WIDTH-1];
    assign o_mode       = 1'b1;
    assign o_shift_amnt = cnt_q;

    assign o_valid = (state_q == S_DONE);
    assign o_busy  = (state_q != S_IDLE);
    assign o_x     = x_q;
    assign o_y     = y_q;
    assign o_z     = z_q;

endmodule
